// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder index collector.
//   IDX_W_DEF / MAX_IMAGES_DEF : default index width and order-RAM depth
//   collector_state_t          : collector FSM encoding (also driven on state_dbg)
//   idx_t                      : image index at the default width
package reorder_pkg;

  localparam int IDX_W_DEF      = 16;
  localparam int MAX_IMAGES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } collector_state_t;

  typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/reorder_index_collector_order_ram.sv
// order_ram: single-port synchronous RAM holding the visiting order.
//   clk   : rising-edge clock
//   en    : port enable; with we=1 writes wdata to addr, with we=0 reads addr
//   we    : write enable
//   addr  : slot address
//   wdata : index to store
//   rdata : registered read data, valid the cycle after a read
// Contents are never reset.
module order_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/reorder_index_collector.sv
// reorder_index_collector: records the reference indices announced by the
// reordering engine and streams the finished visiting order out.
//   start / num_images            : rising edge of start in IDLE begins a job
//   new_reference_is_done / temp_new_reference : engine strobe + index
//   finish_reordering / last_image             : engine completion + final index
//   out_valid/out_ready/out_index/out_position/out_last : result stream
//   done         : one-cycle pulse after the final transfer
//   entry_count  : entries stored so far in the current job
//   overflow_err / count_err / dup_err : sticky job error flags
//   state_dbg    : current FSM state (collector_state_t encoding)
// Optional feature: define REORDER_DUP_CHECK_EN to build the visited-bitmap
// duplicate/range checker; otherwise dup_err is tied low.
//
// Output handshake: an entry transfers on a rising clk edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and
// out_index/out_position/out_last hold while out_valid is high and out_ready
// is low.
module reorder_index_collector
  import reorder_pkg::*;
#(
  parameter int MAX_IMAGES = MAX_IMAGES_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      num_images,
  input  logic             new_reference_is_done,
  input  logic [IDX_W-1:0] temp_new_reference,
  input  logic             finish_reordering,
  input  logic [IDX_W-1:0] last_image,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [15:0]      out_position,
  output logic             out_last,
  output logic             done,
  output logic [15:0]      entry_count,
  output logic             overflow_err,
  output logic             count_err,
  output logic             dup_err,
  output logic [2:0]       state_dbg
);

  localparam int AW    = $clog2(MAX_IMAGES);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IMAGES);

  collector_state_t state, state_next;

  logic             start_q, strobe_q, finish_q;
  logic             start_rise, strobe_rise, finish_rise;
  logic [CNT_W-1:0] count, count_next;
  logic [15:0]      num_lat;
  logic [IDX_W-1:0] pending;

  // Write-side decode
  logic             wr_req, wr_en, load_pending, full;
  logic [IDX_W-1:0] wr_data;
  logic [AW-1:0]    wr_addr;

  // Drain side: read pointer, one read in flight, 2-entry output buffer
  logic [CNT_W-1:0] rd_ptr, out_pos;
  logic             rd_valid, rd_issue, pop;
  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic [IDX_W-1:0] buf0, buf1, ram_rdata;

  logic             ram_en;
  logic [AW-1:0]    ram_addr;

  assign start_rise  = start & ~start_q;
  assign strobe_rise = new_reference_is_done & ~strobe_q;
  assign finish_rise = finish_reordering & ~finish_q;
  assign full        = (count == CNT_MAX);

  always_comb begin
    state_next   = state;
    wr_req       = 1'b0;
    wr_data      = '0;
    load_pending = 1'b0;
    case (state)
      ST_IDLE: begin
        // The engine always starts from image 0, so slot 0 is seeded here.
        if (start_rise) begin
          wr_req     = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (strobe_rise) begin
          wr_req  = 1'b1;
          wr_data = temp_new_reference;
          // Only one write per cycle: park last_image for the next cycle.
          if (finish_rise) begin
            load_pending = 1'b1;
            state_next   = ST_FLUSH;
          end
        end else if (finish_rise) begin
          wr_req     = 1'b1;
          wr_data    = last_image;
          state_next = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        wr_req     = 1'b1;
        wr_data    = pending;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The seed write ignores the stale count of the previous job.
  assign wr_en   = wr_req && ((state == ST_IDLE) || !full);
  assign wr_addr = (state == ST_IDLE) ? '0 : count[AW-1:0];

  always_comb begin
    count_next = count;
    if (state == ST_IDLE && start_rise) count_next = CNT_W'(1);
    else if (wr_en)                     count_next = count + 1'b1;
  end

  // Drain read-ahead: keep buffered + in-flight entries at most 2, counting
  // the slot freed by a same-cycle pop so the stream has no bubbles.
  assign occ      = {1'b0, buf_cnt} + {2'b00, rd_valid};
  assign pop      = out_valid && out_ready;
  assign rd_issue = (state == ST_DRAIN) && (rd_ptr < count) &&
                    ((occ < 3'd2) || ((occ == 3'd2) && pop));

  // Writes and reads live in disjoint states, so one port suffices.
  assign ram_en   = wr_en | rd_issue;
  assign ram_addr = wr_en ? wr_addr : rd_ptr[AW-1:0];

  order_ram #(.DEPTH(MAX_IMAGES), .WIDTH(IDX_W), .AW(AW)) u_order_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      strobe_q     <= 1'b0;
      finish_q     <= 1'b0;
      count        <= '0;
      num_lat      <= '0;
      pending      <= '0;
      overflow_err <= 1'b0;
      count_err    <= 1'b0;
    end else begin
      state    <= state_next;
      start_q  <= start;
      strobe_q <= new_reference_is_done;
      finish_q <= finish_reordering;
      count    <= count_next;
      if (load_pending) pending <= last_image;
      if (state == ST_IDLE && start_rise) begin
        num_lat      <= num_images;
        overflow_err <= 1'b0;
        count_err    <= 1'b0;
      end else begin
        if (wr_req && !wr_en) overflow_err <= 1'b1;
        if (state_next == ST_DRAIN && state != ST_DRAIN &&
            16'(count_next) != num_lat)
          count_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != ST_DRAIN) begin
      rd_ptr   <= '0;
      out_pos  <= '0;
      rd_valid <= 1'b0;
      buf_cnt  <= '0;
      if (reset) begin
        buf0 <= '0;
        buf1 <= '0;
      end
    end else begin
      rd_valid <= rd_issue;
      if (rd_issue) rd_ptr  <= rd_ptr + 1'b1;
      if (pop)      out_pos <= out_pos + 1'b1;
      // buf0 is the head presented on the output port.
      case ({rd_valid, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= ram_rdata;
          else                 buf1 <= ram_rdata;
          buf_cnt <= buf_cnt + 1'b1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 1'b1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) buf0 <= ram_rdata;
          else begin
            buf0 <= buf1;
            buf1 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = (buf_cnt != 2'd0);
  assign out_index    = out_valid ? buf0 : '0;
  assign out_position = out_valid ? 16'(out_pos) : 16'd0;
  assign out_last     = out_valid && (out_pos == (count - 1'b1));
  assign done         = (state == ST_DONE);
  assign entry_count  = 16'(count);
  assign state_dbg    = state;

`ifdef REORDER_DUP_CHECK_EN
  logic [MAX_IMAGES-1:0] visited;
  logic [15:0]           dup_lim;
  logic                  seen, in_range;

  // The seed write checks against the num_images being latched this cycle
  // and against a freshly cleared bitmap.
  assign dup_lim  = (state == ST_IDLE) ? num_images : num_lat;
  assign in_range = (32'(wr_data) < MAX_IMAGES);
  assign seen     = (state != ST_IDLE) && in_range && visited[wr_data[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      visited <= '0;
      dup_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && start_rise) begin
        visited <= '0;
        dup_err <= 1'b0;
      end
      if (wr_en) begin
        if (seen || (32'(wr_data) >= 32'(dup_lim))) dup_err <= 1'b1;
        if (in_range) visited[wr_data[AW-1:0]] <= 1'b1;
      end
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_index_collector.sv
module tb_reorder_index_collector;
  import reorder_pkg::*;

`ifdef REORDER_DUP_CHECK_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_images = '0;
  logic        nrd = 1'b0;
  logic [15:0] temp_ref = '0;
  logic        finish = 1'b0;
  logic [15:0] last_image = '0;
  logic        out_ready = 1'b0;

  // big: default depth; small: depth 4 for the overflow case
  logic        b_valid, b_last, b_done, b_ovf, b_cerr, b_dup;
  logic [15:0] b_index, b_pos, b_count;
  logic [2:0]  b_state;
  logic        s_valid, s_last, s_done, s_ovf, s_cerr, s_dup;
  logic [15:0] s_index, s_pos, s_count;
  logic [2:0]  s_state;

  reorder_index_collector dut (
    .clk(clk), .reset(reset), .start(start), .num_images(num_images),
    .new_reference_is_done(nrd), .temp_new_reference(temp_ref),
    .finish_reordering(finish), .last_image(last_image),
    .out_valid(b_valid), .out_ready(out_ready), .out_index(b_index),
    .out_position(b_pos), .out_last(b_last), .done(b_done),
    .entry_count(b_count), .overflow_err(b_ovf), .count_err(b_cerr),
    .dup_err(b_dup), .state_dbg(b_state)
  );

  reorder_index_collector #(.MAX_IMAGES(4)) dut_small (
    .clk(clk), .reset(reset), .start(start), .num_images(num_images),
    .new_reference_is_done(nrd), .temp_new_reference(temp_ref),
    .finish_reordering(finish), .last_image(last_image),
    .out_valid(s_valid), .out_ready(out_ready), .out_index(s_index),
    .out_position(s_pos), .out_last(s_last), .done(s_done),
    .entry_count(s_count), .overflow_err(s_ovf), .count_err(s_cerr),
    .dup_err(s_dup), .state_dbg(s_state)
  );

  // Selected DUT view for the drain/check tasks
  logic        sel_small = 1'b0;
  logic        o_valid, o_last, o_done, o_ovf, o_cerr, o_dup;
  logic [15:0] o_index, o_pos, o_count;
  logic [2:0]  o_state;
  always_comb begin
    o_valid = sel_small ? s_valid : b_valid;
    o_last  = sel_small ? s_last  : b_last;
    o_done  = sel_small ? s_done  : b_done;
    o_ovf   = sel_small ? s_ovf   : b_ovf;
    o_cerr  = sel_small ? s_cerr  : b_cerr;
    o_dup   = sel_small ? s_dup   : b_dup;
    o_index = sel_small ? s_index : b_index;
    o_pos   = sel_small ? s_pos   : b_pos;
    o_count = sel_small ? s_count : b_count;
    o_state = sel_small ? s_state : b_state;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n);
    num_images = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [15:0] idx, input int hold);
    temp_ref = idx;
    nrd = 1'b1;
    repeat (hold) tick();
    nrd = 1'b0;
    tick();
  endtask

  // Leaves the bench in the first DRAIN cycle.
  task automatic fin(input logic [15:0] last);
    last_image = last;
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_index"}, o_index, 0);
    check({tag, "_pos"},   o_pos, 0);
    check({tag, "_last"},  o_last, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_count"}, o_count, 0);
    check({tag, "_errs"},  {o_ovf, o_cerr, o_dup}, 0);
    check({tag, "_state"}, o_state, ST_IDLE);
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0,...
  task automatic drain(input int mode);
    int pos = 0;
    int cyc = 0;
    int first_hs = -1;
    int n = exp_q.size();
    logic held_v = 1'b0;
    logic [15:0] held_idx = '0;
    logic got_last = 1'b0;
    logic [15:0] e;
    while (!got_last && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (held_v) check("stall_hold", {o_valid, o_index}, {1'b1, held_idx});
      held_v   = o_valid && !out_ready;
      held_idx = o_index;
      if (o_valid && out_ready) begin
        if (first_hs < 0) first_hs = cyc;
        e = exp_q.pop_front();
        check("out_index", o_index, e);
        check("out_position", o_pos, pos);
        check("out_last", o_last, exp_q.size() == 0);
        pos++;
        if (exp_q.size() == 0) begin
          got_last = 1'b1;
          if (mode == 0) check("burst_span", cyc - first_hs + 1, n);
        end
      end
      cyc++;
      tick();
    end
    check("drain_left", exp_q.size(), 0);
    out_ready = 1'b0;
    check("done_pulse", o_done, 1);
    tick();
    check("done_low", o_done, 0);
    check("back_idle", o_state, ST_IDLE);
  endtask

  task automatic settle();
    int cyc = 0;
    out_ready = 1'b1;
    while ((b_state != ST_IDLE || s_state != ST_IDLE) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("settle_idle", {b_state, s_state}, 0);
    out_ready = 1'b0;
    tick();
  endtask

  task automatic normal_job();
    start_job(16'd4);
    strobe(16'd3, 1);
    strobe(16'd1, 1);
    fin(16'd2);
    exp_q = '{16'd0, 16'd3, 16'd1, 16'd2};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int xfers;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    sel_small = 1'b0; check_idle("rst_big");
    sel_small = 1'b1; check_idle("rst_small");

    // Normal job, with drain latency checked explicitly
    sel_small = 1'b0;
    start_job(16'd4);
    check("collect_state", o_state, ST_COLLECT);
    check("seed_count", o_count, 1);
    strobe(16'd3, 1);
    strobe(16'd1, 1);
    check("count_after_2", o_count, 3);
    fin(16'd2);
    check("drain_state", o_state, ST_DRAIN);
    check("count_final", o_count, 4);
    check("lat_valid0", o_valid, 0);
    tick();
    check("lat_valid1", o_valid, 0);
    tick();
    check("lat_valid2", o_valid, 1);
    exp_q = '{16'd0, 16'd3, 16'd1, 16'd2};
    drain(0);
    check("normal_errs", {o_ovf, o_cerr, o_dup}, 0);
    check("count_holds", o_count, 4);
    settle();

    // Backpressure on the small instance
    sel_small = 1'b1;
    normal_job();
    drain(1);
    check("bp_errs", {o_ovf, o_cerr, o_dup}, 0);
    settle();

    // Held strobe then simultaneous strobe/finish
    sel_small = 1'b0;
    start_job(16'd8);
    strobe(16'd1, 4);
    check("held_strobe_count", o_count, 2);
    temp_ref = 16'd5; last_image = 16'd7;
    nrd = 1'b1; finish = 1'b1;
    tick();
    nrd = 1'b0; finish = 1'b0;
    check("flush_state", o_state, ST_FLUSH);
    tick();
    check("flush_to_drain", o_state, ST_DRAIN);
    check("simul_count", o_count, 4);
    exp_q = '{16'd0, 16'd1, 16'd5, 16'd7};
    drain(0);
    check("simul_count_err", o_cerr, 1);
    check("simul_dup", o_dup, 0);
    settle();

    // Overflow on the depth-4 instance
    sel_small = 1'b1;
    start_job(16'd4);
    for (int i = 1; i <= 5; i++) strobe(16'(i), 1);
    fin(16'd6);
    exp_q = '{16'd0, 16'd1, 16'd2, 16'd3};
    drain(0);
    check("ovf_small", s_ovf, 1);
    check("ovf_small_count", s_count, 4);
    check("ovf_small_cerr", s_cerr, 0);
    check("ovf_big_count", b_count, 7);
    check("ovf_big_flags", {b_ovf, b_cerr, b_dup}, {1'b0, 1'b1, DUP_EN});
    settle();

    // Count mismatch: 4 stored, 6 expected
    sel_small = 1'b0;
    start_job(16'd6);
    strobe(16'd3, 1);
    strobe(16'd1, 1);
    fin(16'd2);
    exp_q = '{16'd0, 16'd3, 16'd1, 16'd2};
    drain(0);
    check("cerr_both", {b_cerr, s_cerr}, 2'b11);
    settle();

    // Reset after two transfers, then a fresh job
    normal_job();
    exp_q.delete();
    out_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 2; c++) begin
      if (b_valid) xfers++;
      tick();
    end
    check("pre_reset_xfers", xfers, 2);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    sel_small = 1'b0; check_idle("mid_rst_big");
    sel_small = 1'b1; check_idle("mid_rst_small");
    sel_small = 1'b0;
    tick();
    normal_job();
    drain(0);
    check("fresh_errs", {o_ovf, o_cerr, o_dup}, 0);
    settle();

    // Duplicate and out-of-range indices
    start_job(16'd4);
    strobe(16'd2, 1);
    strobe(16'd2, 1);
    fin(16'd3);
    exp_q = '{16'd0, 16'd2, 16'd2, 16'd3};
    drain(0);
    check("dup_repeat", {b_dup, s_dup}, {DUP_EN, DUP_EN});
    settle();
    start_job(16'd4);
    check("dup_cleared", b_dup, 0);
    strobe(16'd1, 1);
    strobe(16'd9, 1);
    fin(16'd2);
    exp_q = '{16'd0, 16'd1, 16'd9, 16'd2};
    drain(0);
    check("dup_range", b_dup, DUP_EN);
    check("dup_range_cerr", b_cerr, 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_index_collector.md
# reorder_index_collector

Downstream stage of the reordering engine inside `top`. Captures each reference index the engine announces on `new_reference_is_done`/`temp_new_reference`. On `finish_reordering` it appends `last_image`, then streams the complete visiting order out through a valid/ready port. The block replaces host-side polling of the engine with a hardware-ordered result list.

## Interface
- `MAX_IMAGES`, 1024: order-RAM depth (max entries per job).
- `IDX_W`, 16: image index width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level from host; its rising edge in IDLE begins a job.
- `num_images` in 16: expected entry count, sampled on the start edge.
- `new_reference_is_done` in 1: engine strobe, captured on its rising edge.
- `temp_new_reference` in IDX_W: index valid while the strobe is high.
- `finish_reordering` in 1: engine completion, captured on its rising edge.
- `last_image` in IDX_W: final index, valid with `finish_reordering`.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_index` out IDX_W: reordered image index.
- `out_position` out 16: slot number of `out_index`, starting at 0.
- `out_last` out 1: high with the final entry.
- `done` out 1: one-cycle pulse after the final transfer.
- `entry_count` out 16: entries stored so far.
- `overflow_err` out 1: sticky; a write was attempted with the RAM full.
- `count_err` out 1: sticky; entry count at drain differs from `num_images`.
- `dup_err` out 1: sticky; only driven with the macro enabled.

## Operation
- States: IDLE, COLLECT, FLUSH, DRAIN, DONE.
- IDLE, on start rising edge:
  - Latch `num_images`, clear the error flags.
  - Write index 0 to slot 0 (the engine always begins at image 0), set count=1.
  - Go to COLLECT.
  - A start edge in any other state is ignored.
- COLLECT, on a strobe rising edge: write `temp_new_reference` to slot count, then count++.
- COLLECT, on a finish rising edge: write `last_image`, then go to DRAIN.
- If the strobe edge and the finish edge occur in the same cycle:
  - Write `temp_new_reference` that cycle.
  - Hold `last_image` in a pending register, go to FLUSH.
  - FLUSH writes the pending value next cycle, then goes to DRAIN.
- Full RAM: when count == MAX_IMAGES, writes are dropped, count saturates and `overflow_err` is set. The job still finishes normally.
- On entry to DRAIN: if count != latched `num_images`, set `count_err`.
- DRAIN:
  - Read slots 0..count-1 in order.
  - `out_index`/`out_position` hold stable while `out_valid` is high and `out_ready` is low.
  - `out_last` is high when `out_position` == count-1.
  - Transfer of the last entry moves to DONE.
- DONE: `done` is high for one cycle, then the block returns to IDLE. `entry_count` holds its value until the next start.
- Reset at any time:
  - State returns to IDLE; count, pointers and edge-detect registers clear.
  - RAM contents are not cleared.
- Widths: count and pointers are log2(MAX_IMAGES)+1 bits, zero-extended onto 16-bit outputs.

## Timing
- Reset values: all outputs 0.
- Edge detect: a registered copy of each strobe. A strobe held high for several cycles captures exactly once.
- Capture: edge sampled at cycle t, RAM written at the end of cycle t, `entry_count` updates at t+1.
- Drain latency: `out_valid` first rises 2 cycles after entering DRAIN (registered RAM read plus output register).
- Throughput: one entry per cycle while `out_ready` is held high. This uses a read-ahead into a 2-entry output buffer, so no bubbles.
- `done` is asserted in the cycle after the `out_last` handshake.

## Configuration
- `REORDER_DUP_CHECK_EN` defined:
  - A MAX_IMAGES-bit visited bitmap is cleared on the start edge.
  - Every write checks the bitmap. If the index is already set, or the index is ≥ latched `num_images`, `dup_err` is set (sticky); the write still occurs.
- `REORDER_DUP_CHECK_EN` undefined: no bitmap logic; `dup_err` is tied to 0.

## Structure
- Package `reorder_pkg`:
  - `IDX_W` and MAX_IMAGES defaults.
  - `collector_state_t` enum (IDLE, COLLECT, FLUSH, DRAIN, DONE).
  - `idx_t` typedef.
- Sub-module `order_ram`: single-port synchronous RAM, 1-cycle read latency, MAX_IMAGES×IDX_W. Writes happen only in COLLECT/FLUSH and reads only in DRAIN, so a single port is sufficient.

## Test plan
- **Normal job:** num_images=4, strobes with 3, 1 and finish last_image=2, out_ready=1 → outputs 0, 3, 1, 2 on consecutive cycles at positions 0–3. `out_last` with 2, `done` 1 cycle later, all error flags 0.
- **Backpressure:** same job, out_ready toggling 1,0,0,1… → no loss or duplication. `out_index` is stable during every stall.
- **Simultaneous edges:** strobe (index 5) and finish (last_image 7) in the same cycle → FLUSH visited, order ends …, 5, 7. Also: a strobe held high 4 cycles → exactly 1 entry.
- **Overflow/mismatch:** MAX_IMAGES=4, 5 strobes then finish → `overflow_err`=1, `entry_count`=4, 4 entries drained. Separately, num_images=6 with only 4 stored → `count_err`=1.
- **Reset mid-DRAIN:** reset asserted after 2 transfers → outputs 0 and state IDLE on the next cycle. A fresh job then runs correctly.
- **Duplicate check** (with `REORDER_DUP_CHECK_EN`): strobes 2, 2 → `dup_err`=1. Index 9 with num_images=4 → `dup_err`=1. Without the macro, `dup_err` stays 0.
